// File: rtl/bram_stream_reader_pkg.sv
// Shared widths, controller state encoding and default FIFO entry layout for the BRAM stream reader.
// Pure declarations: no latency, no flow control.
package bram_stream_reader_pkg;

    localparam int BL_W_DEF   = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int LEN_W_DEF  = ADDR_W_DEF + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic                last;
        logic [BL_W_DEF-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Request, RAM read port and output stream of the BRAM stream reader.
// master = the controller; slave = requester, RAM brick and downstream consumer.
interface bram_stream_reader_if
  import bram_stream_reader_pkg::*;
#(
  parameter int BL_WIDTH   = BL_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_base;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [BL_WIDTH-1:0]   mem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [BL_WIDTH-1:0]   out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  req_valid, req_base, req_len, mem_rdata, out_ready,
    output req_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    output req_valid, req_base, req_len, mem_rdata, out_ready,
    input  req_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/bram_rd_skid_fifo.sv
// Small synchronous FIFO holding RAM words whose reads are already committed; head is read straight from storage flops.
// Zero-cycle push-to-visible latency is not offered: a pushed word is at the head the cycle after the push edge.
module bram_rd_skid_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fifo_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_dat,
  input  logic             pop,
  output entry_t           head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             full;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_next(wr_ptr);
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !do_pop)      count <= count + CNT_W'(1);
      else if (!push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // The controller only issues a read when a slot is guaranteed, so a full push is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/bram_stream_reader.sv
// Walks a (base, len) burst over a 1-cycle-latency BRAM and streams the words out; first word 3 cycles after acceptance.
// Reads are issued only when the output FIFO can absorb them, so backpressure never drops an in-flight word.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int BL_WIDTH   = BL_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int FIFO_DEPTH = 2
) (
  input logic                  CLK,
  input logic                  rst,
  bram_stream_reader_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic                last;
    logic [BL_WIDTH-1:0] data;
  } entry_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  rd_en;
  logic                  pop;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [OCC_W-1:0]      occ;
  entry_t                push_ent;
  entry_t                head;

  assign pop = !fifo_empty && bus.out_ready;
  // Slots committed after this edge if no new read is issued.
  assign occ = OCC_W'(fifo_cnt) + OCC_W'(inflight_q) - OCC_W'(pop);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_base;
          rem_d   = bus.req_len;
          state_d = (bus.req_len == '0) ? FIN : READ;
        end
      end
      READ: begin
        if (occ < OCC_W'(FIFO_DEPTH)) begin
          rd_en  = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as the last word is popped so done lands the cycle after that handshake.
        if (!inflight_q && (fifo_cnt == '0 || (fifo_cnt == CNT_W'(1) && pop))) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && (rem_q == LEN_WIDTH'(1));
    end
  end

  assign push_ent = '{last: inflight_last_q, data: bus.mem_rdata};

  bram_rd_skid_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (CLK),
    .rst      (rst),
    .push     (inflight_q),
    .push_dat (push_ent),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = addr_q;
  assign bus.out_valid   = !fifo_empty;
  assign bus.out_data    = head.data;
  assign bus.out_last    = head.last;
  assign bus.busy        = (state_q == READ) || (state_q == DRAIN);
  assign bus.done        = (state_q == FIN);
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: directed bursts plus random bursts under random backpressure,
// checked against a burst-level model (expected word queue, address queue, done timing).
module tb_bram_stream_reader;
  localparam int BLW   = 16;
  localparam int AW    = 4;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 2;
  localparam int RAM_N = 1 << AW;

  typedef struct {
    logic [BLW-1:0] d;
    logic           l;
  } word_t;

  logic CLK = 1'b0;
  logic rst = 1'b1;

  bram_stream_reader_if #(.BL_WIDTH(BLW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  bram_stream_reader #(
    .BL_WIDTH   (BLW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Registered-read RAM brick.
  logic [BLW-1:0] ram [RAM_N];
  logic [BLW-1:0] rdata_q;
  always @(posedge CLK) if (bus.mem_rd_en) rdata_q <= ram[bus.mem_rd_addr];
  assign bus.mem_rdata = rdata_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Consumer ready generation.
  int       rdy_mode = 0;
  logic [5:0] pat = 6'b101001;
  int       pat_i = 0;
  always begin
    case (rdy_mode)
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      2: begin
        bus.out_ready = pat[pat_i];
        pat_i = (pat_i + 1) % 6;
      end
      default: bus.out_ready = 1'b1;
    endcase
    @(posedge CLK);
    #1;
  end

  // Reference model state.
  word_t         exp_q[$];
  logic [AW-1:0] adr_q[$];
  bit            model_idle = 1'b1;
  bit            done_exp   = 1'b0;
  bit            idle_now;
  bit            nd;
  word_t         w;
  int            issued = 0, popped = 0;
  bit            stalled = 1'b0;
  logic [BLW-1:0] st_d;
  logic          st_l;
  int            cyc = 0, acc_cnt = 0, acc_cyc = -1, done_cyc = -1;
  int            first_rd = -1, last_rd = -1, first_vld = -1, hs_burst = 0;

  always @(negedge CLK) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      adr_q.delete();
      model_idle = 1'b1;
      done_exp   = 1'b0;
      issued     = 0;
      popped     = 0;
      stalled    = 1'b0;
    end else begin
      idle_now = model_idle;
      nd       = 1'b0;
      chk("req_ready", bus.req_ready, idle_now);
      chk("done", bus.done, done_exp);
      chk("busy", bus.busy, !idle_now && !done_exp);
      chk("occupancy", (issued - popped) <= DEPTH, 1);
      if (bus.mem_rd_en) begin
        if (adr_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", bus.mem_rd_addr, adr_q.pop_front());
        issued++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (stalled) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, st_d);
        chk("stall_last", bus.out_last, st_l);
      end
      if (bus.out_valid && first_vld < 0) first_vld = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("out_data", bus.out_data, w.d);
          chk("out_last", bus.out_last, w.l);
          if (w.l) nd = 1'b1;
        end
        popped++;
        hs_burst++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      st_d    = bus.out_data;
      st_l    = bus.out_last;
      if (done_exp) begin
        model_idle = 1'b1;
        done_cyc   = cyc;
      end
      if (bus.req_valid && idle_now) begin
        model_idle = 1'b0;
        for (int i = 0; i < int'(bus.req_len); i++) begin
          w.d = ram[AW'((int'(bus.req_base) + i) % RAM_N)];
          w.l = (i == int'(bus.req_len) - 1);
          exp_q.push_back(w);
          adr_q.push_back(AW'((int'(bus.req_base) + i) % RAM_N));
        end
        if (bus.req_len == '0) nd = 1'b1;
        acc_cnt++;
        acc_cyc   = cyc;
        first_rd  = -1;
        last_rd   = -1;
        first_vld = -1;
        hs_burst  = 0;
      end
      done_exp = nd;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] b, input logic [LW-1:0] l);
    int a0 = acc_cnt;
    bus.req_valid = 1'b1;
    bus.req_base  = b;
    bus.req_len   = l;
    for (int i = 0; i < 400 && acc_cnt == a0; i++) step();
    if (acc_cnt == a0) chk("accept_timeout", 0, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (i < 600 && !(model_idle && !done_exp)) begin
      step();
      i++;
    end
    if (!(model_idle && !done_exp)) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int a1;
    for (int i = 0; i < RAM_N; i++) ram[i] = BLW'($urandom);
    bus.req_valid = 1'b0;
    bus.req_base  = '0;
    bus.req_len   = '0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_rd_addr", bus.mem_rd_addr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    step();

    // Basic burst and latency.
    rdy_mode = 0;
    send(4'd5, 5'd4);
    wait_idle();
    chk("lat_first_rd", first_rd - acc_cyc, 1);
    chk("rd_span", last_rd - first_rd, 3);
    chk("lat_first_vld", first_vld - acc_cyc, 3);
    chk("lat_done", done_cyc - acc_cyc, 7);
    step();

    // Zero length.
    send(4'd9, 5'd0);
    wait_idle();
    chk("zero_no_rd", first_rd, -1);
    chk("zero_no_vld", first_vld, -1);
    chk("zero_done", done_cyc - acc_cyc, 1);
    step();

    // Address wrap.
    send(4'd14, 5'd4);
    wait_idle();
    chk("wrap_words", hs_burst, 4);
    step();

    // Backpressure pattern 1,0,0,1,0,1...
    rdy_mode = 2;
    pat_i    = 0;
    send(4'd3, 5'd8);
    wait_idle();
    chk("bp_words", hs_burst, 8);
    rdy_mode = 0;
    step();

    // Reset after the third word of eight.
    send(4'd0, 5'd8);
    for (int i = 0; i < 100 && hs_burst < 3; i++) step();
    chk("mid_rst_reached", hs_burst >= 3, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_req_ready", bus.req_ready, 1);
    chk("mid_rst_rd_en", bus.mem_rd_en, 0);
    chk("mid_rst_rd_addr", bus.mem_rd_addr, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    rst = 1'b0;
    step();
    send(4'd0, 5'd2);
    wait_idle();
    chk("post_rst_words", hs_burst, 2);
    step();

    // Back-to-back: second request held valid while busy.
    bus.req_valid = 1'b1;
    bus.req_base  = 4'd2;
    bus.req_len   = 5'd3;
    a1 = acc_cnt;
    for (int i = 0; i < 50 && acc_cnt == a1; i++) step();
    chk("b2b_first_acc", acc_cnt - a1, 1);
    bus.req_base = 4'd7;
    bus.req_len  = 5'd2;
    a1 = acc_cnt;
    for (int i = 0; i < 100 && acc_cnt == a1; i++) step();
    chk("b2b_second_acc", acc_cnt - a1, 1);
    chk("b2b_gap", acc_cyc - done_cyc, 1);
    bus.req_valid = 1'b0;
    wait_idle();
    step();

    // Random bursts, random backpressure.
    for (int k = 0; k < 16; k++) begin
      rdy_mode = (k % 3 == 2) ? 2 : 1;
      send(AW'($urandom), LW'($urandom_range(0, RAM_N)));
      wait_idle();
      repeat ($urandom_range(0, 3)) step();
    end
    rdy_mode = 0;
    repeat (3) step();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side controller for a simple dual-port block RAM with 1-cycle registered read latency. Read enable and address are sampled at a clock edge; data appears on the RAM's read-data bus in the next cycle and holds until the next enabled read.
- Accepts a burst request (base address, length) and walks the addresses.
- Streams the words out on a valid/ready interface with full backpressure support, without losing any read already in flight.
- Sits between a RAM brick and downstream merge/compute consumers.

Parameters:
- BL_WIDTH, `LIM_BRICK_WORD_SIZE, data word width.
- ADDR_WIDTH, `BITS_ADDR_LIM_BRICK, RAM address width.
- LEN_WIDTH, ADDR_WIDTH+1, burst length width (allows a full-RAM burst).
- FIFO_DEPTH, 2, output buffer entries; must be >= 2.

Ports:
- CLK  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  burst request valid
- req_ready  out  1  controller can accept a request
- req_base  in  ADDR_WIDTH  first address
- req_len  in  LEN_WIDTH  number of words; 0 is legal
- mem_rd_en  out  1  RAM read enable
- mem_rd_addr  out  ADDR_WIDTH  RAM read address
- mem_rdata  in  BL_WIDTH  RAM read data, valid the cycle after mem_rd_en
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts word
- out_data  out  BL_WIDTH  output word
- out_last  out  1  marks final word of burst
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after burst completes

Behaviour:
- Clock and reset: single clock CLK. rst is synchronous and active-high.
- Reset values: req_ready=1, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_last=0, busy=0, done=0. FIFO emptied, in-flight flag cleared, FSM in IDLE.
- Reset mid-burst: the burst is abandoned. Any read in flight is discarded, and no done pulse is produced.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch base and len and set busy=1. If len=0, go to FIN; else go to READ.
  - READ: issue reads. After the final address is issued, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, return to IDLE. req_ready stays 0 in FIN.
- Read issue rule, in READ state: mem_rd_en=1 when (fifo_count + inflight - (out_valid & out_ready)) < FIFO_DEPTH.
- On each issued read:
  - Address increments modulo 2^ADDR_WIDTH, wrapping from max to 0.
  - Remaining count decrements.
  - inflight is set for the next cycle.
- mem_rd_en and mem_rd_addr are driven combinationally from registered state. No read is issued in IDLE, DRAIN or FIN.
- Capture: in the cycle after mem_rd_en=1, mem_rdata is pushed into the FIFO at the clock edge. mem_rdata is never captured in any other cycle.
- Output:
  - out_valid = FIFO not empty. out_data and out_last come from the FIFO head.
  - out_last is stored per entry; it is set on the word read for the final address.
  - The word holds stable while out_valid=1 and out_ready=0.
  - Pop occurs when out_valid & out_ready.
  - Push and pop may happen in the same cycle; the count is unchanged.
- Latency, with the request accepted at edge T:
  - mem_rd_en in cycle T+1.
  - First out_valid in cycle T+3.
  - With out_ready held at 1, the FIFO sustains one word per cycle.
  - done pulses the cycle after the last word's handshake.
- Overflow: by construction the FIFO never overflows. An assertion flags any push while full.
- req_valid is ignored while busy=1.

Decomposition:
- Shared package holds:
  - Width constants for BL, ADDR and LEN.
  - State enum: IDLE, READ, DRAIN, FIN.
  - Typedef of the FIFO entry struct: data, last.
- One sub-module: bram_rd_skid_fifo. It is a synchronous, parameterised-depth FIFO with push/pop/count and registered head outputs, cleared by rst.

Test Plan:
- Basic burst: base=5, len=4, out_ready=1 -> mem_rd_addr 5,6,7,8 in consecutive cycles starting T+1. Data words for addresses 5..8 appear in cycles T+3..T+6, out_last on the 4th word, done at T+7.
- Zero length: req_len=0 -> no mem_rd_en, no out_valid, done pulses the cycle after acceptance, req_ready returns to 1.
- Address wrap: ADDR_WIDTH=4, base=14, len=4 -> addresses 14,15,0,1 and data match RAM contents in order.
- Backpressure: len=8, out_ready toggled 1,0,0,1,0,1... -> no word lost or duplicated, out_data stable while stalled, FIFO occupancy never exceeds 2, mem_rd_en stalls accordingly.
- Reset mid-burst: rst asserted for 1 cycle after the 3rd word of 8 -> all outputs at reset values next cycle, no done pulse. A new request base=0, len=2 afterwards completes normally.
- Back-to-back requests: req_valid held with a second request -> accepted only in the cycle after done, req_ready=0 throughout busy.
